// File: rtl/tempsense_pkg.sv
// Shared constants for the tempsense measurement controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, DAC code constants, blanking length.
package tempsense_pkg;

  // FSM state encoding; 5..7 are illegal and recover to IDLE.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_TRANS = 3'd2;
  localparam logic [2:0] ST_MEAS  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // DAC constants, sliced down to DAC_BITS by the user.
  localparam logic [31:0] DAC_ALL_ONES = '1;
  localparam logic [31:0] DAC_ZERO     = '0;

  // MEASURE cycles during which a low delay pulse does not end the sample;
  // covers the synchroniser latency so stale pre-MEASURE data is ignored.
  localparam int BLANK_CYC = 2;

endpackage

// File: rtl/tempsense_sync.sv
// Two-flop synchroniser for the asynchronous tempdelay pulse.
// Latency: 2 clk cycles from d to q.
// Backpressure: none (free running).
// Ports: clk, reset (async, active-high, clears to 0), d (async in), q (synchronised out).
module tempsense_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tempsense_meas_ctrl.sv
// Self-timed precharge/transition/measure sequencer that digitises the tempsense delay pulse.
// Latency: start to o_valid = 1 + PRE_CYC + TRANS_CYC + P + 3 cycles per sample (P = pulse length).
// Backpressure: result held in DONE with o_valid=1 until i_ready; i_start is ignored outside IDLE.
// Ports: clk/reset (async active-high); i_start, i_continuous, i_dac_cfg, i_tempdelay, i_ready in;
//        o_dac_data, o_dac_en, o_precharge_n to the core; o_result, o_overflow, o_valid, o_busy, o_state out.
// Optional feature: define TEMPSENSE_AVG_EN to average 2^AVG_LOG samples (AVG_LOG >= 1) per result.
module tempsense_meas_ctrl
  import tempsense_pkg::*;
#(
  parameter int DAC_BITS  = 5,
  parameter int CNT_BITS  = 12,
  parameter int PRE_CYC   = 4,
  parameter int TRANS_CYC = 2,
  parameter int AVG_LOG   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_continuous,
  input  logic [DAC_BITS-1:0] i_dac_cfg,
  input  logic                i_tempdelay,
  input  logic                i_ready,
  output logic [DAC_BITS-1:0] o_dac_data,
  output logic                o_dac_en,
  output logic                o_precharge_n,
  output logic [CNT_BITS-1:0] o_result,
  output logic                o_overflow,
  output logic                o_valid,
  output logic                o_busy,
  output logic [2:0]          o_state
);

  // Phase counter must reach the longest phase length and the blanking length.
  localparam int PH_MAX0 = (PRE_CYC > TRANS_CYC) ? PRE_CYC : TRANS_CYC;
  localparam int PH_MAX  = (PH_MAX0 > BLANK_CYC) ? PH_MAX0 : BLANK_CYC;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [2:0]          state, nxt;
  logic [PH_W-1:0]     ph;
  logic [CNT_BITS-1:0] cnt;
  logic [DAC_BITS-1:0] cfg;
  logic                sync;
  logic                blank, samp_end, last_samp, arm;
  logic [CNT_BITS-1:0] res_val;
  logic                ovf_val;

  // Output decode of the next state, registered so outputs line up with o_state.
  logic                nx_en, nx_pn, nx_busy, nx_vld;
  logic [DAC_BITS-1:0] nx_dat;

  tempsense_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_tempdelay),
    .q     (sync)
  );

  assign o_state  = state;
  assign blank    = (ph < PH_W'(BLANK_CYC));
  assign samp_end = (cnt == CNT_MAX) || (!blank && !sync);
  // A new conversion (not a follow-on averaging sample) starts here.
  assign arm      = ((state == ST_IDLE) || (state == ST_DONE)) && (nxt == ST_PRE);

`ifdef TEMPSENSE_AVG_EN
  localparam int ACC_W = CNT_BITS + AVG_LOG;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic [AVG_LOG-1:0] samp;
  logic               ovf_acc;

  assign acc_sum   = acc + ACC_W'(cnt);
  assign last_samp = (samp == '1);
  assign res_val   = acc_sum[ACC_W-1:AVG_LOG];
  assign ovf_val   = ovf_acc | (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      samp    <= '0;
      ovf_acc <= 1'b0;
    end else if (arm) begin
      acc     <= '0;
      samp    <= '0;
      ovf_acc <= 1'b0;
    end else if ((state == ST_MEAS) && samp_end) begin
      acc     <= acc_sum;
      samp    <= samp + AVG_LOG'(1);
      ovf_acc <= ovf_val;
    end
  end
`else
  assign last_samp = 1'b1;
  assign res_val   = cnt;
  assign ovf_val   = (cnt == CNT_MAX);
`endif

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (i_start || i_continuous) nxt = ST_PRE;
      ST_PRE:   if (ph == PH_W'(PRE_CYC - 1)) nxt = ST_TRANS;
      ST_TRANS: if (ph == PH_W'(TRANS_CYC - 1)) nxt = ST_MEAS;
      ST_MEAS:  if (samp_end) nxt = last_samp ? ST_DONE : ST_PRE;
      ST_DONE:  if (i_ready) nxt = i_continuous ? ST_PRE : ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    nx_en   = 1'b1;
    nx_dat  = DAC_ALL_ONES[DAC_BITS-1:0];
    nx_pn   = 1'b0;
    nx_busy = 1'b0;
    nx_vld  = 1'b0;
    case (nxt)
      ST_PRE:   nx_busy = 1'b1;
      ST_TRANS: begin
        nx_dat  = DAC_ZERO[DAC_BITS-1:0];
        nx_pn   = 1'b1;
        nx_busy = 1'b1;
      end
      ST_MEAS: begin
        nx_dat  = cfg;
        nx_pn   = 1'b1;
        nx_busy = 1'b1;
      end
      ST_DONE:  nx_vld = 1'b1;
      default:  nx_en  = 1'b0;
    endcase
    // cfg is loaded on the same edge as entering PRECHARGE, so MEASURE always
    // sees the latched value; no bypass of i_dac_cfg is needed here.
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      ph            <= '0;
      cnt           <= '0;
      cfg           <= '0;
      o_result      <= '0;
      o_overflow    <= 1'b0;
      o_dac_en      <= 1'b0;
      o_dac_data    <= DAC_ALL_ONES[DAC_BITS-1:0];
      o_precharge_n <= 1'b0;
      o_busy        <= 1'b0;
      o_valid       <= 1'b0;
    end else begin
      state <= nxt;

      // Phase timer restarts on every state change and parks at PH_MAX.
      if (nxt != state)               ph <= '0;
      else if (ph != PH_W'(PH_MAX))   ph <= ph + PH_W'(1);

      if (arm) cfg <= i_dac_cfg;

      if (nxt == ST_PRE)
        cnt <= '0;
      else if ((state == ST_MEAS) && sync && (cnt != CNT_MAX))
        cnt <= cnt + CNT_BITS'(1);

      if ((state == ST_MEAS) && samp_end && last_samp) begin
        o_result   <= res_val;
        o_overflow <= ovf_val;
      end

      o_dac_en      <= nx_en;
      o_dac_data    <= nx_dat;
      o_precharge_n <= nx_pn;
      o_busy        <= nx_busy;
      o_valid       <= nx_vld;
    end
  end

endmodule
